uncache_agent: RTL and testbench



---
 rtl/uncache_agent_pkg.sv | 42 ++++
 rtl/uncache_agent.sv | 94 +++++++++
 tb/tb_uncache_agent.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uncache_agent_pkg.sv
// Shared types for the uncached-access agent: FSM encoding, bus size codes
// and the store-strobe to size/offset mapping.
package uncache_agent_pkg;

  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned OFF_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'd2;

  typedef struct packed {
    logic [SIZE_W-1:0] size;
    logic [OFF_W-1:0]  off;
  } size_off_t;

  // Irregular strobes fall back to a word access with the strobe passed through.
  function automatic size_off_t strb_to_size_off(input logic [STRB_W-1:0] strb);
    size_off_t r;
    r.size = SZ_WORD;
    r.off  = 2'd0;
    case (strb)
      4'b0001: begin r.size = SZ_BYTE; r.off = 2'd0; end
      4'b0010: begin r.size = SZ_BYTE; r.off = 2'd1; end
      4'b0100: begin r.size = SZ_BYTE; r.off = 2'd2; end
      4'b1000: begin r.size = SZ_BYTE; r.off = 2'd3; end
      4'b0011: begin r.size = SZ_HALF; r.off = 2'd0; end
      4'b1100: begin r.size = SZ_HALF; r.off = 2'd2; end
      default: begin r.size = SZ_WORD; r.off = 2'd0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uncache_agent.sv
// Turns one uncached core data access into a single SRAM-like bus transaction,
// stalling the pipeline until it completes and holding the returned load data.
module uncache_agent
  import uncache_agent_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                data_sram_en,
  input  logic [STRB_W-1:0]   data_sram_we,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  input  logic                uncached,
  output logic [DATA_W-1:0]   uncache_rdata,
  output logic                stallreq_uncache,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [SIZE_W-1:0]   bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [STRB_W-1:0]   bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  state_e    state_q;
  logic      start_c;
  size_off_t so_c;

  assign start_c = data_sram_en && uncached;

  // Reads are always word accesses; the MEM stage picks out the byte/half.
  always_comb begin
    so_c = '{size: SZ_WORD, off: 2'd0};
    if (|data_sram_we) so_c = strb_to_size_off(data_sram_we);
  end

  // DONE deliberately drops the stall so the still-presented access is not re-taken.
  assign stallreq_uncache = ((state_q == ST_IDLE) && start_c) ||
                            (state_q == ST_REQ) || (state_q == ST_WAIT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      bus_req       <= 1'b0;
      bus_wr        <= 1'b0;
      bus_size      <= SZ_BYTE;
      bus_addr      <= '0;
      bus_wstrb     <= '0;
      bus_wdata     <= '0;
      uncache_rdata <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            state_q   <= ST_REQ;
            bus_req   <= 1'b1;
            bus_wr    <= |data_sram_we;
            bus_size  <= so_c.size;
            bus_addr  <= {data_sram_addr[ADDR_W-1:OFF_W], so_c.off};
            bus_wstrb <= data_sram_we;
            bus_wdata <= data_sram_wdata;
          end
        end
        ST_REQ: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            if (bus_data_ok) begin
              state_q <= ST_DONE;
              if (!bus_wr) uncache_rdata <= bus_rdata;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus_data_ok) begin
            state_q <= ST_DONE;
            if (!bus_wr) uncache_rdata <= bus_rdata;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A response before the request is accepted is a bus protocol error.
  a_no_early_data_ok: assert property (@(posedge clk) disable iff (!resetn)
    !((state_q == ST_REQ) && bus_data_ok && !bus_addr_ok));

endmodule

// File: tb/tb_uncache_agent.sv
// Directed bench for uncache_agent: reads, stores, wait states, fast response,
// back-to-back accesses and asynchronous reset mid-transaction.
module tb_uncache_agent;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        uncached;
  logic [31:0] uncache_rdata;
  logic        stallreq_uncache;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int req_base;

  uncache_agent dut (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_en     (data_sram_en),
    .data_sram_we     (data_sram_we),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .uncached         (uncached),
    .uncache_rdata    (uncache_rdata),
    .stallreq_uncache (stallreq_uncache),
    .bus_req          (bus_req),
    .bus_wr           (bus_wr),
    .bus_size         (bus_size),
    .bus_addr         (bus_addr),
    .bus_wstrb        (bus_wstrb),
    .bus_wdata        (bus_wdata),
    .bus_addr_ok      (bus_addr_ok),
    .bus_data_ok      (bus_data_ok),
    .bus_rdata        (bus_rdata)
  );

  always #5 clk = ~clk;

  // Accepted bus requests.
  always @(posedge clk) if (resetn && bus_req && bus_addr_ok) req_cnt <= req_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    data_sram_en = 1'b1; uncached = 1'b1;
    data_sram_we = we; data_sram_addr = addr; data_sram_wdata = wd;
  endtask

  initial begin
    resetn = 1'b0; data_sram_en = 1'b0; data_sram_we = 4'h0; data_sram_addr = '0;
    data_sram_wdata = '0; uncached = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    bus_rdata = '0;
    repeat (2) tick();
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(stallreq_uncache), 32'd0);
    chk("rst_rdata", uncache_rdata, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wr_size", {29'd0, bus_wr, bus_size}, 32'd0);
    resetn = 1'b1;

    // 1: word read, addr_ok in REQ, data_ok next cycle
    tick();
    access(4'h0, 32'hBFAF_8000, 32'h0); #1;
    chk("rd_idle_stall", 32'(stallreq_uncache), 32'd1);
    chk("rd_idle_noreq", 32'(bus_req), 32'd0);
    tick(); bus_addr_ok = 1'b1; #1;
    chk("rd_req", 32'(bus_req), 32'd1);
    chk("rd_addr", bus_addr, 32'hBFAF_8000);
    chk("rd_size", 32'(bus_size), 32'd2);
    chk("rd_wr", 32'(bus_wr), 32'd0);
    chk("rd_req_stall", 32'(stallreq_uncache), 32'd1);
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678; #1;
    chk("rd_wait_req", 32'(bus_req), 32'd0);
    chk("rd_wait_stall", 32'(stallreq_uncache), 32'd1);
    tick(); bus_data_ok = 1'b0; data_sram_en = 1'b0; #1;
    chk("rd_done_stall", 32'(stallreq_uncache), 32'd0);
    chk("rd_done_data", uncache_rdata, 32'h1234_5678);
    tick();
    chk("rd_held", uncache_rdata, 32'h1234_5678);
    chk("rd_idle_req", 32'(bus_req), 32'd0);

    // 2: byte store, lane 2
    access(4'b0100, 32'hBFAF_F020, 32'h00AB_0000); #1;
    chk("sb_stall", 32'(stallreq_uncache), 32'd1);
    tick(); bus_addr_ok = 1'b1; #1;
    chk("sb_wr", 32'(bus_wr), 32'd1);
    chk("sb_size", 32'(bus_size), 32'd0);
    chk("sb_addr", bus_addr, 32'hBFAF_F022);
    chk("sb_wstrb", 32'(bus_wstrb), 32'h4);
    chk("sb_wdata", bus_wdata, 32'h00AB_0000);
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
    tick(); bus_data_ok = 1'b0; data_sram_en = 1'b0; #1;
    chk("sb_done_stall", 32'(stallreq_uncache), 32'd0);
    chk("sb_rdata_kept", uncache_rdata, 32'h1234_5678);
    tick();

    // 3: half store, upper half, addr_ok withheld for 4 REQ cycles
    access(4'b1100, 32'hBFAF_F010, 32'h1234_0000); #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sh_req", 32'(bus_req), 32'd1);
      chk("sh_stall", 32'(stallreq_uncache), 32'd1);
      chk("sh_fields", {bus_addr[15:0], 10'd0, bus_size, bus_wstrb}, {16'hF012, 10'd0, 2'd1, 4'hC});
    end
    tick(); bus_addr_ok = 1'b1; #1;
    chk("sh_req5", 32'(bus_req), 32'd1);
    chk("sh_addr", bus_addr, 32'hBFAF_F012);
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; #1;
    chk("sh_wait_stall", 32'(stallreq_uncache), 32'd1);
    tick(); bus_data_ok = 1'b0; data_sram_en = 1'b0; #1;
    chk("sh_done_stall", 32'(stallreq_uncache), 32'd0);
    chk("sh_rdata_kept", uncache_rdata, 32'h1234_5678);
    tick();

    // 4: addr_ok and data_ok together in REQ
    access(4'h0, 32'hBFAF_8006, 32'h0); #1;
    chk("ff_idle_stall", 32'(stallreq_uncache), 32'd1);
    tick(); bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D; #1;
    chk("ff_addr", bus_addr, 32'hBFAF_8004);
    chk("ff_req_stall", 32'(stallreq_uncache), 32'd1);
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b0; data_sram_en = 1'b0; #1;
    chk("ff_done_stall", 32'(stallreq_uncache), 32'd0);
    chk("ff_rdata", uncache_rdata, 32'hCAFE_F00D);
    tick();

    // 5: back-to-back reads, en held through DONE
    req_base = req_cnt;
    access(4'h0, 32'hBFAF_8100, 32'h0);
    tick(); bus_addr_ok = 1'b1; #1;
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111; #1;
    tick(); bus_data_ok = 1'b0; #1;
    chk("bb_done_stall", 32'(stallreq_uncache), 32'd0);
    chk("bb_rdata1", uncache_rdata, 32'h1111_1111);
    tick(); data_sram_addr = 32'hBFAF_8200; #1;
    chk("bb_idle_noreq", 32'(bus_req), 32'd0);
    chk("bb_idle_stall", 32'(stallreq_uncache), 32'd1);
    tick(); bus_addr_ok = 1'b1; #1;
    chk("bb_addr2", bus_addr, 32'hBFAF_8200);
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2222_2222; #1;
    tick(); bus_data_ok = 1'b0; data_sram_en = 1'b0; #1;
    chk("bb_rdata2", uncache_rdata, 32'h2222_2222);
    tick();
    chk("bb_req_count", 32'(req_cnt - req_base), 32'd2);

    // 6: asynchronous reset while in WAIT
    access(4'h0, 32'hBFAF_8300, 32'h0);
    tick(); bus_addr_ok = 1'b1; #1;
    tick(); bus_addr_ok = 1'b0; #2;
    resetn = 1'b0; data_sram_en = 1'b0; #1;
    chk("ar_req", 32'(bus_req), 32'd0);
    chk("ar_stall", 32'(stallreq_uncache), 32'd0);
    chk("ar_rdata", uncache_rdata, 32'h0);
    tick(); resetn = 1'b1;
    tick();
    access(4'h0, 32'hBFAF_8400, 32'h0);
    tick(); bus_addr_ok = 1'b1; #1;
    chk("ar2_addr", bus_addr, 32'hBFAF_8400);
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h55AA_55AA; #1;
    tick(); bus_data_ok = 1'b0; data_sram_en = 1'b0; #1;
    chk("ar2_rdata", uncache_rdata, 32'h55AA_55AA);
    chk("ar2_stall", 32'(stallreq_uncache), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
